reset_stage_sequencer: RTL and testbench

//  Consumes the fabric reset produced by the CORERESET_PF stage, driven as RST = !FABRIC_RESET_N.

---
 rtl/reset_stage_sequencer.sv | 167 ++++++++++++++++
 tb/tb_reset_stage_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_stage_sequencer.sv
// rtl/reset_stage_sequencer.sv - staged release of downstream reset domains qualified on PLL lock and per-stage ack
module reset_stage_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 1024,
    parameter int LOCK_FILTER = 8,
    parameter int MAX_RETRY   = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PLL_LOCK,
    input  logic [N_STAGES-1:0] STAGE_ACK,
    output logic [N_STAGES-1:0] STAGE_RST,
    output logic                SEQ_DONE,
    output logic                SEQ_FAULT,
    output logic [3:0]          RETRY_CNT
);

    localparam int DW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [DW-1:0] D_LAST   = DW'(STAGE_DELAY - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [FW-1:0] F_FULL   = FW'(LOCK_FILTER);
    localparam logic [IW-1:0] I_LAST   = IW'(N_STAGES - 1);
    localparam logic [3:0]    R_MAX    = 4'(MAX_RETRY);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_DELAY     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_RETRY     = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    logic          lock_meta;
    logic          lock_s;
    logic [FW-1:0] fcnt;
    logic          lock_ok;
    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt;
    logic          ack_cur;

    assign lock_ok = (fcnt == F_FULL);
    assign ack_cur = STAGE_ACK[idx];

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
        end
    end

    // Lock filter: count consecutive synced-high cycles, saturating at LOCK_FILTER
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fcnt <= '0;
        end else if (!lock_s) begin
            fcnt <= '0;
        end else if (fcnt != F_FULL) begin
            fcnt <= fcnt + 1'b1;
        end
    end

    // Sequencer FSM; lock loss outranks everything while stages are live
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_WAIT_LOCK;
            idx       <= '0;
            dcnt      <= '0;
            tcnt      <= '0;
            STAGE_RST <= '1;
            SEQ_DONE  <= 1'b0;
            SEQ_FAULT <= 1'b0;
            RETRY_CNT <= 4'd0;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    STAGE_RST <= '1;
                    SEQ_DONE  <= 1'b0;
                    idx       <= '0;
                    dcnt      <= '0;
                    if (lock_ok) begin
                        state <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (!lock_s) begin
                        STAGE_RST <= '1;
                        SEQ_DONE  <= 1'b0;
                        idx       <= '0;
                        state     <= S_WAIT_LOCK;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == D_LAST) begin
                            STAGE_RST[idx] <= 1'b0;
                            tcnt           <= '0;
                            state          <= S_WAIT_ACK;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (!lock_s) begin
                        STAGE_RST <= '1;
                        SEQ_DONE  <= 1'b0;
                        idx       <= '0;
                        state     <= S_WAIT_LOCK;
                    end else if (ack_cur) begin
                        if (idx == I_LAST) begin
                            SEQ_DONE <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            dcnt  <= '0;
                            state <= S_DELAY;
                        end
                    end else if (tcnt == T_LAST) begin
                        STAGE_RST <= '1;
                        state     <= S_RETRY;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RETRY: begin
                    STAGE_RST <= '1;
                    idx       <= '0;
                    if (RETRY_CNT == R_MAX) begin
                        SEQ_FAULT <= 1'b1;
                        state     <= S_FAULT;
                    end else begin
                        RETRY_CNT <= RETRY_CNT + 4'd1;
                        state     <= S_WAIT_LOCK;
                    end
                end
                S_DONE: begin
                    if (!lock_s) begin
                        STAGE_RST <= '1;
                        SEQ_DONE  <= 1'b0;
                        idx       <= '0;
                        state     <= S_WAIT_LOCK;
                    end else begin
                        SEQ_DONE <= 1'b1;
                    end
                end
                S_FAULT: begin
                    STAGE_RST <= '1;
                    SEQ_DONE  <= 1'b0;
                    SEQ_FAULT <= 1'b1;
                end
                default: begin
                    STAGE_RST <= '1;
                    SEQ_DONE  <= 1'b0;
                    idx       <= '0;
                    state     <= S_WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_stage_sequencer.sv
// tb/tb_reset_stage_sequencer.sv - directed self-checking bench for reset_stage_sequencer
module tb_reset_stage_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PLL_LOCK = 1'b0;
    logic [3:0] STAGE_ACK = 4'h0;
    logic [3:0] STAGE_RST;
    logic       SEQ_DONE;
    logic       SEQ_FAULT;
    logic [3:0] RETRY_CNT;

    int cyc = 0;
    int base = 0;
    int total = 0;
    int bad = 0;

    reset_stage_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .PLL_LOCK  (PLL_LOCK),
        .STAGE_ACK (STAGE_ACK),
        .STAGE_RST (STAGE_RST),
        .SEQ_DONE  (SEQ_DONE),
        .SEQ_FAULT (SEQ_FAULT),
        .RETRY_CNT (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int edge_now();
        return cyc - base;
    endfunction

    task automatic do_reset();
        RST       = 1'b1;
        PLL_LOCK  = 1'b1;
        STAGE_ACK = 4'h0;
        repeat (3) @(negedge CLK);
        RST  = 1'b0;
        base = cyc;
    endtask

    task automatic wait_release(input int i, input int exp_edge, input string nm);
        int k;
        k = 0;
        while (STAGE_RST[i] !== 1'b0 && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        total++;
        if (STAGE_RST[i] !== 1'b0 || edge_now() != exp_edge) begin
            $display("FAIL %s: stage %0d release edge=%0d rst=%b, expected edge %0d", nm, i, edge_now(), STAGE_RST[i], exp_edge);
            bad++;
        end
    endtask

    task automatic ack_after5(input int i);
        repeat (4) @(negedge CLK);
        STAGE_ACK[i] = 1'b1;
    endtask

    // full sequence from the release of stage 0 at edge 'first' to SEQ_DONE
    task automatic run_sequence(input int first, input logic [3:0] exp_retry, input string nm);
        wait_release(0, first, nm);
        total++;
        if (STAGE_RST !== 4'hE) begin
            $display("FAIL %s_only_stage0: STAGE_RST=%h expected e", nm, STAGE_RST);
            bad++;
        end
        ack_after5(0);
        wait_release(1, first + 21, nm);
        ack_after5(1);
        wait_release(2, first + 42, nm);
        ack_after5(2);
        wait_release(3, first + 63, nm);
        repeat (4) @(negedge CLK);
        total++;
        if (SEQ_DONE !== 1'b0) begin
            $display("FAIL %s_done_early: SEQ_DONE=%b expected 0", nm, SEQ_DONE);
            bad++;
        end
        STAGE_ACK[3] = 1'b1;
        @(negedge CLK);
        total++;
        if (SEQ_DONE !== 1'b1 || STAGE_RST !== 4'h0 || RETRY_CNT !== exp_retry || edge_now() != first + 68) begin
            $display("FAIL %s_done: SEQ_DONE=%b STAGE_RST=%h RETRY_CNT=%0d edge=%0d expected 1/0/%0d/%0d",
                     nm, SEQ_DONE, STAGE_RST, RETRY_CNT, edge_now(), exp_retry, first + 68);
            bad++;
        end
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        PLL_LOCK = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if (STAGE_RST !== 4'hF || SEQ_DONE !== 1'b0 || SEQ_FAULT !== 1'b0 || RETRY_CNT !== 4'd0) begin
            $display("FAIL reset: STAGE_RST=%h DONE=%b FAULT=%b RETRY=%0d expected f/0/0/0",
                     STAGE_RST, SEQ_DONE, SEQ_FAULT, RETRY_CNT);
            bad++;
        end
    endtask

    task automatic test_nominal();
        do_reset();
        run_sequence(27, 4'd0, "nominal");
        STAGE_ACK = 4'h0;
        repeat (5) @(negedge CLK);
        total++;
        if (SEQ_DONE !== 1'b1 || STAGE_RST !== 4'h0) begin
            $display("FAIL done_hold: SEQ_DONE=%b STAGE_RST=%h expected 1/0", SEQ_DONE, STAGE_RST);
            bad++;
        end
    endtask

    task automatic test_lock_glitch();
        do_reset();
        wait_release(0, 27, "glitch");
        ack_after5(0);
        wait_release(1, 48, "glitch");
        ack_after5(1);
        wait_release(2, 69, "glitch");
        STAGE_ACK = 4'h0;
        PLL_LOCK  = 1'b0;
        @(negedge CLK);
        PLL_LOCK  = 1'b1;
        @(negedge CLK);
        total++;
        if (STAGE_RST !== 4'h8) begin
            $display("FAIL glitch_sync_delay: STAGE_RST=%h expected 8", STAGE_RST);
            bad++;
        end
        @(negedge CLK);
        total++;
        if (STAGE_RST !== 4'hF || SEQ_DONE !== 1'b0) begin
            $display("FAIL glitch_drop: STAGE_RST=%h SEQ_DONE=%b expected f/0", STAGE_RST, SEQ_DONE);
            bad++;
        end
        wait_release(0, 97, "glitch_restart");
        total++;
        if (RETRY_CNT !== 4'd0) begin
            $display("FAIL glitch_retry: RETRY_CNT=%0d expected 0", RETRY_CNT);
            bad++;
        end
    endtask

    task automatic test_single_timeout();
        do_reset();
        wait_release(0, 27, "timeout");
        ack_after5(0);
        wait_release(1, 48, "timeout");
        repeat (1023) @(negedge CLK);
        total++;
        if (STAGE_RST !== 4'hC) begin
            $display("FAIL timeout_early: STAGE_RST=%h expected c", STAGE_RST);
            bad++;
        end
        @(negedge CLK);
        total++;
        if (STAGE_RST !== 4'hF || RETRY_CNT !== 4'd0) begin
            $display("FAIL timeout_retry_state: STAGE_RST=%h RETRY_CNT=%0d expected f/0", STAGE_RST, RETRY_CNT);
            bad++;
        end
        @(negedge CLK);
        total++;
        if (RETRY_CNT !== 4'd1) begin
            $display("FAIL timeout_retry_cnt: RETRY_CNT=%0d expected 1", RETRY_CNT);
            bad++;
        end
        STAGE_ACK = 4'h0;
        run_sequence(1090, 4'd1, "timeout_rerun");
    endtask

    task automatic test_persistent();
        int k;
        int nchg;
        logic [3:0] prev;
        logic [3:0] seen [3];
        logic stable;
        do_reset();
        STAGE_ACK = 4'h7;
        k = 0;
        nchg = 0;
        prev = 4'd0;
        seen[0] = 4'd0;
        seen[1] = 4'd0;
        seen[2] = 4'd0;
        while (SEQ_FAULT !== 1'b1 && k < 8000) begin
            @(negedge CLK);
            k++;
            if (RETRY_CNT !== prev) begin
                if (nchg < 3) seen[nchg] = RETRY_CNT;
                nchg++;
                prev = RETRY_CNT;
            end
        end
        total++;
        if (nchg != 3 || seen[0] !== 4'd1 || seen[1] !== 4'd2 || seen[2] !== 4'd3) begin
            $display("FAIL retry_steps: changes=%0d seq=%0d,%0d,%0d expected 3 changes 1,2,3",
                     nchg, seen[0], seen[1], seen[2]);
            bad++;
        end
        total++;
        if (SEQ_FAULT !== 1'b1 || STAGE_RST !== 4'hF || SEQ_DONE !== 1'b0 || RETRY_CNT !== 4'd3) begin
            $display("FAIL fault_state: FAULT=%b STAGE_RST=%h DONE=%b RETRY=%0d expected 1/f/0/3",
                     SEQ_FAULT, STAGE_RST, SEQ_DONE, RETRY_CNT);
            bad++;
        end
        stable = 1'b1;
        for (int j = 0; j < 60; j++) begin
            PLL_LOCK  = ~PLL_LOCK;
            STAGE_ACK = (j % 2 == 0) ? 4'hF : 4'h0;
            @(negedge CLK);
            if (SEQ_FAULT !== 1'b1 || STAGE_RST !== 4'hF || SEQ_DONE !== 1'b0 || RETRY_CNT !== 4'd3)
                stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1) begin
            $display("FAIL fault_sticky: outputs moved while in fault, now FAULT=%b STAGE_RST=%h", SEQ_FAULT, STAGE_RST);
            bad++;
        end
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if (SEQ_FAULT !== 1'b0 || RETRY_CNT !== 4'd0) begin
            $display("FAIL fault_clear: FAULT=%b RETRY=%0d expected 0/0", SEQ_FAULT, RETRY_CNT);
            bad++;
        end
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        wait_release(0, 27, "ack_timeout");
        repeat (1023) @(negedge CLK);
        total++;
        if (STAGE_RST !== 4'hE) begin
            $display("FAIL ack_timeout_pre: STAGE_RST=%h expected e", STAGE_RST);
            bad++;
        end
        STAGE_ACK[0] = 1'b1;
        @(negedge CLK);
        total++;
        if (STAGE_RST !== 4'hE || RETRY_CNT !== 4'd0) begin
            $display("FAIL ack_timeout_win: STAGE_RST=%h RETRY_CNT=%0d expected e/0", STAGE_RST, RETRY_CNT);
            bad++;
        end
        wait_release(1, 1067, "ack_timeout_next");
    endtask

    task automatic test_rst_mid_delay();
        do_reset();
        wait_release(0, 27, "rst_mid");
        ack_after5(0);
        wait_release(1, 48, "rst_mid");
        ack_after5(1);
        repeat (5) @(negedge CLK);
        total++;
        if (STAGE_RST !== 4'hC) begin
            $display("FAIL rst_mid_pre: STAGE_RST=%h expected c", STAGE_RST);
            bad++;
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (STAGE_RST !== 4'hF || SEQ_DONE !== 1'b0) begin
            $display("FAIL rst_async: STAGE_RST=%h SEQ_DONE=%b expected f/0", STAGE_RST, SEQ_DONE);
            bad++;
        end
        do_reset();
        run_sequence(27, 4'd0, "rst_rerun");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_single_timeout();
        test_persistent();
        test_ack_at_timeout();
        test_rst_mid_delay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
